// File: rtl/debounced_counter_bank.sv
// Multi-channel debounced event counter: per-channel 2-FF sync, 4-state debounce FSM,
// press detector and wrap/saturate counter. Optional auto-repeat via DEBOUNCE_AUTOREPEAT_EN.
module debounced_counter_bank #(
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned CNT_W         = 4,
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned WRAP          = 1,
    parameter int unsigned HOLD_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_CH-1:0]       noisy,
    input  logic [NUM_CH-1:0]       clr,
    output logic [NUM_CH-1:0]       debounced,
    output logic [NUM_CH-1:0]       press,
    output logic [NUM_CH*CNT_W-1:0] count,
    output logic [NUM_CH-1:0]       overflow
);

    localparam int unsigned T_MAX_A = (DEB_CYCLES > HOLD_CYCLES) ? DEB_CYCLES : HOLD_CYCLES;
    localparam int unsigned T_MAX   = (T_MAX_A > REPEAT_CYCLES) ? T_MAX_A : REPEAT_CYCLES;
    localparam int unsigned TIMER_W = $clog2(T_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t             state;
        state_t             state_nxt;
        logic               s1;
        logic               s2;
        logic               deb_q;
        logic               done_c;
        logic               press_c;
        logic               rep_fire_c;
        logic [TIMER_W-1:0] timer;
        logic [CNT_W-1:0]   cnt;
        logic               ovf;
        logic               press_r;

        // Two-flop synchroniser for the asynchronous pin
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                s1 <= 1'b0;
                s2 <= 1'b0;
            end else begin
                s1 <= noisy[i];
                s2 <= s1;
            end
        end

        assign done_c = (timer == TIMER_W'(DEB_CYCLES - 1));

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                state <= IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                IDLE: if (s2) state_nxt = RISE;
                RISE: if (!s2) state_nxt = IDLE; else if (done_c) state_nxt = HIGH;
                HIGH: if (!s2) state_nxt = FALL;
                FALL: if (s2) state_nxt = HIGH; else if (done_c) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end

        // Stability timer runs only while a transition is being qualified
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                timer <= '0;
                deb_q <= 1'b0;
            end else begin
                timer <= (state == RISE || state == FALL) ? timer + TIMER_W'(1) : '0;
                deb_q <= debounced[i];
            end
        end

        assign debounced[i] = (state == HIGH) || (state == FALL);

`ifdef DEBOUNCE_AUTOREPEAT_EN
        logic [TIMER_W-1:0] rep_timer;
        logic               repeating;

        // First fire after the hold delay, then every repeat period while held in HIGH
        assign rep_fire_c = (state == HIGH) &&
            (rep_timer == (repeating ? TIMER_W'(REPEAT_CYCLES) : TIMER_W'(HOLD_CYCLES)));

        always_ff @(posedge clk) begin
            if (!reset_n || state != HIGH) begin
                rep_timer <= '0;
                repeating <= 1'b0;
            end else if (rep_fire_c) begin
                rep_timer <= TIMER_W'(1);
                repeating <= 1'b1;
            end else begin
                rep_timer <= rep_timer + TIMER_W'(1);
            end
        end
`else
        assign rep_fire_c = 1'b0;
`endif

        assign press_c = (debounced[i] & ~deb_q) | rep_fire_c;

        // Clear wins over a same-cycle press; a full counter flags overflow
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cnt     <= '0;
                ovf     <= 1'b0;
                press_r <= 1'b0;
            end else begin
                press_r <= press_c;
                if (clr[i]) begin
                    cnt <= '0;
                    ovf <= 1'b0;
                end else if (press_c) begin
                    if (cnt != {CNT_W{1'b1}}) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        ovf <= 1'b1;
                        if (WRAP != 0) cnt <= '0;
                    end
                end
            end
        end

        assign press[i]                  = press_r;
        assign overflow[i]               = ovf;
        assign count[i*CNT_W +: CNT_W]   = cnt;
    end

endmodule

// File: doc/debounced_counter_bank.md
# debounced_counter_bank

Parametrised multi-channel debounced event counter for board push-buttons and other noisy, slow inputs. Each of `NUM_CH` channels has its own 2-FF synchroniser, 4-state debounce FSM, rising-edge press detector, and `CNT_W`-bit counter. Counters can wrap or saturate, have a sticky overflow flag, and clear per channel. An optional auto-repeat mode adds repeat presses while an input is held. The block sits between raw top-level button pins and user logic such as LED displays or menu controllers.

## Interface
- `NUM_CH`, 4: number of independent channels.
- `CNT_W`, 4: counter width per channel.
- `DEB_CYCLES`, 500000: input stability time, in clocks. Must be ≥ 2.
- `WRAP`, 1: 1 = counter wraps to 0; 0 = counter saturates at all-ones.
- `HOLD_CYCLES`, 50000000: auto-repeat initial delay. Used only with the macro.
- `REPEAT_CYCLES`, 10000000: auto-repeat period. Used only with the macro.

- `clk`  in  1  single clock; all logic is `posedge clk`.
- `reset_n`  in  1  synchronous, active-low reset.
- `noisy`  in  NUM_CH  raw asynchronous inputs, one bit per channel.
- `clr`  in  NUM_CH  synchronous per-channel clear of count and overflow.
- `debounced`  out  NUM_CH  debounced level.
- `press`  out  NUM_CH  one-cycle pulse per counted event.
- `count`  out  NUM_CH*CNT_W  counters; channel i occupies `[i*CNT_W +: CNT_W]`.
- `overflow`  out  NUM_CH  sticky flag, set on a wrap or saturate attempt.

## Operation
- Synchroniser: `s1 <= noisy`, `s2 <= s1`. The FSM sees only `s2`.
- Timer: one per channel, width `$clog2(max(DEB_CYCLES,HOLD_CYCLES,REPEAT_CYCLES)+1)`. Cleared in IDLE and HIGH; increments in RISE and FALL. `done = (timer == DEB_CYCLES-1)`.
- FSM (Moore), evaluated per channel:
  - IDLE: `s2=1` → RISE; else stay.
  - RISE: `s2=0` → IDLE; else if `done` → HIGH; else stay.
  - HIGH: `s2=0` → FALL; else stay.
  - FALL: `s2=1` → HIGH; else if `done` → IDLE; else stay.
- `debounced` is 1 in HIGH and FALL, 0 in IDLE and RISE; decoded from the state register.
- `press` is registered: `press <= debounced & ~debounced_q`, where `debounced_q` is `debounced` delayed one clock. A FALL→HIGH return does not pulse, because `debounced` stays 1.
- Counter update on each edge, in priority order:
  - `clr` → count=0, overflow=0.
  - Else if the press condition holds:
    - count < max → count+1.
    - count == max with WRAP=1 → count=0, overflow=1.
    - count == max with WRAP=0 → count held, overflow=1.
- Channels are fully independent; simultaneous events on different channels do not interact.
- Reset (`reset_n=0` at an edge) puts every channel in this state:
  - FSM in IDLE.
  - s1, s2, timers, `debounced_q`, and the repeat timer all 0.
  - Outputs `debounced=0`, `press=0`, `count=0`, `overflow=0`.
  
  Reset mid-debounce abandons the operation, and no press is generated from it.

## Timing
- Input `noisy` rises before edge k and stays stable. Then:
  - s2=1 after edge k+1.
  - FSM enters RISE after edge k+2.
  - FSM enters HIGH, and `debounced=1`, after edge k+2+DEB_CYCLES.
  - `press=1` and the counter increment both occur after edge k+3+DEB_CYCLES.
- A high pulse shorter than DEB_CYCLES+1 clocks at s2 never asserts `debounced`.
- Release: `debounced` falls DEB_CYCLES+2 edges after `noisy` falls, with the same structure as the rising path.
- `clr` takes effect on the edge at which it is sampled. It overrides a same-cycle press, and that press is lost.

## Configuration
- Macro: `DEBOUNCE_AUTOREPEAT_EN`.
- Defined:
  - Each channel has a repeat timer. It clears on entry to HIGH and increments while in HIGH.
  - Additional `press` pulses (each counted) occur HOLD_CYCLES clocks after the initial press, then every REPEAT_CYCLES clocks while the channel stays in HIGH.
  - Leaving HIGH stops repeats. Re-entry from FALL restarts the hold delay without an initial press.
- Undefined:
  - No repeat logic is built. `HOLD_CYCLES` and `REPEAT_CYCLES` are ignored.
  - Exactly one press per `debounced` rising edge.

## Test plan
Bench parameters are `DEB_CYCLES=4`, `CNT_W=3`, `NUM_CH=4`, except where a test overrides them.

1. Hold `reset_n=0` for 3 cycles with `noisy=4'hF`. Every output must be 0. Release reset and hold `noisy=0`; outputs must stay 0.
2. Step `noisy[0]` 0→1 before edge 10 and hold it. Required response:
   - `debounced[0]=1` after edge 16.
   - `press[0]` high only after edge 17.
   - `count[0]=1`.
   - Channels 1–3 unchanged.
3. Glitch rejection and release bounce:
   - Pulse `noisy[1]` high for 3 cycles → `debounced[1]` stays 0 and `count[1]=0`.
   - On a held channel, drop the input low for 2 cycles then raise it → `debounced` stays 1 and there is no second press.
4. Wrap and clear:
   - With WRAP=1, apply 8 clean presses to channel 2 → `count[2]=0`, `overflow[2]=1`.
   - Pulse `clr[2]` → count=0, overflow=0.
   - Assert `clr[2]` on the same cycle as a press → count stays 0.
5. Saturate: with WRAP=0, apply 9 presses → `count=7` and `overflow=1` after the 8th press. The count holds at 7.
6. Auto-repeat, with `DEBOUNCE_AUTOREPEAT_EN`, HOLD_CYCLES=10, REPEAT_CYCLES=5:
   - Hold channel 3 in HIGH for 30 clocks → 5 press pulses, at offsets +0, +10, +15, +20, +25 from the first. `count[3]=5`.
   - Same stimulus without the macro → `count[3]=1`.
